// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MULT_RUN,
    DIV_RUN,
    WB,
    DZ
  } state_e;

  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  localparam int unsigned MULT_CYCLES_DEF = 32;
  localparam int unsigned DIV_CYCLES_DEF  = 32;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_cnt.sv
// Loadable down-counter that saturates at zero.
module muldiv_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the HI/LO multiply/divide path: accepts UC requests,
// times the unit latency, steers the HI/LO muxes and issues the write.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_req,
  input  logic        div_req,
  input  logic [31:0] divisor,
  input  logic        hilo_rd,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        div_init,
  output logic        op_hi_sel,
  output logic        op_lo_sel,
  output logic        hi_write,
  output logic        lo_write,
  output logic        stall
);

  localparam int unsigned CW =
    $clog2(max2(MULT_CYCLES, DIV_CYCLES) + 1);

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          load;
  logic [CW-1:0] ld_val;
  logic          cnt_en;
  logic          cnt_zero;

  logic busy_q, done_q, dz_q, init_q;

  muldiv_cnt #(
    .W(CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .load_i(load),
    .val_i (ld_val),
    .en_i  (cnt_en),
    .zero_o(cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    load    = 1'b0;
    ld_val  = '0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Multiply wins a collision; the divide is dropped silently.
        if (mult_req) begin
          state_d = MULT_RUN;
          load    = 1'b1;
          ld_val  = MULT_LD;
          sel_d   = SEL_MULT;
        end else if (div_req) begin
          if (divisor == '0) begin
            state_d = DZ;
          end else begin
            state_d = DIV_RUN;
            load    = 1'b1;
            ld_val  = DIV_LD;
            sel_d   = SEL_DIV;
          end
        end
      end
      MULT_RUN, DIV_RUN: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_d = WB;
        end
      end
      WB:      state_d = IDLE;
      DZ:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= SEL_DIV;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == WB);
      dz_q    <= (state_d == DZ);
      init_q  <= (state_q == IDLE) && (state_d == DIV_RUN);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi_write  = done_q;
  assign lo_write  = done_q;
  assign div_zero  = dz_q;
  assign div_init  = init_q;
  assign op_hi_sel = sel_q;
  assign op_lo_sel = sel_q;
  assign stall     = hilo_rd & busy_q;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

- Sequencer for the CPU's HI/LO multiply/divide path.
- Accepts a one-cycle MULT or DIV request from the main control unit (UC) and starts the divider with a one-cycle init pulse.
- Counts the fixed unit latency, steers the HI/LO source muxes, and issues the single HI/LO write.
- Reports completion, divide-by-zero, and read-after-busy stalls back to UC.
- Sits between UC and the mult/div units, the HI/LO muxes and the HI/LO registers.

## Interface

Parameters:
- MULT_CYCLES, 32, number of RUN cycles for a multiply; must be ≥1
- DIV_CYCLES, 32, number of RUN cycles for a divide; must be ≥1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; reset = 0 clears all state immediately
- mult_req  in  1  one-cycle request from UC to start a multiply
- div_req  in  1  one-cycle request from UC to start a divide
- divisor  in  32  B operand, sampled in the same cycle as div_req
- hilo_rd  in  1  UC is executing mfhi/mflo this cycle
- busy  out  1  operation in progress; UC must not issue requests
- done  out  1  one-cycle pulse in the writeback cycle
- div_zero  out  1  one-cycle pulse; divide aborted, divisor = 0
- div_init  out  1  one-cycle start pulse to the divider
- op_hi_sel  out  1  HI mux select: 0 = divider, 1 = multiplier
- op_lo_sel  out  1  LO mux select: 0 = divider, 1 = multiplier
- hi_write  out  1  HI register load enable
- lo_write  out  1  LO register load enable
- stall  out  1  combinational: hilo_rd & busy

## Operation

FSM states: IDLE, MULT_RUN, DIV_RUN, WB, DZ.

IDLE:
- mult_req = 1 → MULT_RUN. Load the counter with MULT_CYCLES-1. Set both selects to 1.
- div_req = 1 and divisor = 0 → DZ.
- div_req = 1 and divisor ≠ 0 → DIV_RUN. Load the counter with DIV_CYCLES-1. Set both selects to 0.
- mult_req and div_req both high → multiply wins; div_req is dropped and no div_zero is raised.
- No request → stay in IDLE.

MULT_RUN / DIV_RUN:
- Counter decrements each cycle.
- At count 0 → WB.
- div_init = 1 only in the first DIV_RUN cycle.

WB:
- hi_write = lo_write = 1 and done = 1 for exactly one cycle, then → IDLE.

DZ:
- div_zero = 1 for one cycle, then → IDLE.
- No hi_write/lo_write and no div_init; HI/LO keep their previous contents.

Other rules:
- mult_req or div_req outside IDLE are ignored; they are not queued.
- busy = 1 in MULT_RUN, DIV_RUN, WB and DZ.
- Selects hold their value through RUN and WB and keep the last value in IDLE; they change only on an accepted request.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1). It never wraps; decrementing stops at 0.
- Reset asserted mid-operation: → IDLE with counter 0. Any write not yet performed is lost; no pulse is generated on reset release.

## Timing

- Reset values: all outputs 0, state IDLE, counter 0, both selects 0.
- Request sampled at edge E0. busy rises after E0.
- RUN occupies N cycles (N = MULT_CYCLES or DIV_CYCLES). WB is the (N+1)th cycle after E0.
- HI/LO load at the edge ending WB. busy falls after that edge. A new request is accepted in the cycle after WB.
- Divide-by-zero: div_zero is high in the cycle after E0; busy is high for that cycle only.
- hi_write, lo_write, done, div_zero, div_init, busy and both selects are registered.
- stall is combinational, so UC sees it in the same cycle as hilo_rd.

## Structure

- Package muldiv_pkg holds:
  - the state enum (IDLE, MULT_RUN, DIV_RUN, WB, DZ);
  - select constants SEL_DIV = 1'b0 and SEL_MULT = 1'b1;
  - default cycle counts.
- One sub-module, muldiv_cnt:
  - loadable down-counter with a zero flag;
  - ports: load, load value, enable;
  - stops at 0.
- FSM and output registers stay in muldiv_ctrl.

## Test plan

- Reset: hold reset = 0 while toggling requests → every output stays 0. Release reset → no output pulses.
- Multiply, MULT_CYCLES = 32: mult_req pulse → busy high 33 cycles; selects = 1; hi_write = lo_write = done = 1 only in cycle 33; next-cycle mult_req accepted.
- Divide, divisor = 7, DIV_CYCLES = 32: div_init pulse in cycle 1; selects = 0; WB in cycle 33; stall = 1 whenever hilo_rd = 1 during cycles 1–33, 0 afterwards.
- Divide by zero, divisor = 0: div_zero = 1 in cycle 1 only; no div_init, no writes; busy low from cycle 2.
- Collisions:
  - mult_req and div_req in the same cycle → multiply path only.
  - div_req during MULT_RUN → ignored; the multiply completes unchanged.
- Reset mid-op: reset = 0 during cycle 10 of a divide → all outputs 0 immediately. After release, no done or write pulse; a fresh mult_req completes normally.
